// File: rtl/bmp_pix_writer_if.sv
// Pixel-writer bus: byte stream and frame control in, RGB444 raster writes out.
// The master side drives the byte stream; the slave side is bmp_pix_writer.
interface bmp_pix_writer_if;
   logic        start;
   logic        abort;
   logic        byte_vld;
   logic [7:0]  byte_dat;
   logic        w_en;
   logic [18:0] addr_w;
   logic [11:0] dat_w;
   logic        busy;
   logic        done;

   modport master (
      output start, abort, byte_vld, byte_dat,
      input  w_en, addr_w, dat_w, busy, done
   );

   modport slave (
      input  start, abort, byte_vld, byte_dat,
      output w_en, addr_w, dat_w, busy, done
   );
endinterface

// File: rtl/bmp_pix_writer.sv
// 24bpp BMP byte stream to RGB444 raster writes: skips the file header, packs B,G,R
// into one pixel and turns the stored row order into top-down raster addresses.
module bmp_pix_writer #(
   parameter int IMG_W     = 640,
   parameter int IMG_H     = 480,
   parameter int HDR_BYTES = 54,
   parameter int BOTTOM_UP = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   bmp_pix_writer_if.slave   bus
);
   localparam int COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int HDR_W    = (HDR_BYTES > 1) ? $clog2(HDR_BYTES) : 1;
   localparam int HDR_LAST = (HDR_BYTES > 0) ? HDR_BYTES - 1 : 0;

   localparam logic [18:0]      ROW_STEP   = 19'(IMG_W);
   localparam logic [18:0]      TOP_BASE   = 19'((IMG_H - 1) * IMG_W);
   localparam logic [18:0]      FIRST_BASE = (BOTTOM_UP != 0) ? TOP_BASE : 19'd0;
   localparam logic [18:0]      LAST_BASE  = (BOTTOM_UP != 0) ? 19'd0 : TOP_BASE;
   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_W - 1);
   localparam logic [HDR_W-1:0] HDR_END    = HDR_W'(HDR_LAST);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_PIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [HDR_W-1:0] hdr_cnt_q, hdr_cnt_d;
   logic [1:0]       phase_q, phase_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [18:0]      row_base_q, row_base_d;
   logic [3:0]       b_q, b_d;
   logic [3:0]       g_q, g_d;
   logic             w_en_q, w_en_d;
   logic [18:0]      addr_q, addr_d;
   logic [11:0]      dat_q, dat_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             unused_s;

   // Only the colour nibbles are kept; the low bits of every byte are dropped.
   assign unused_s = ^bus.byte_dat[3:0];

   // Next-state logic: abort wins over everything, then the frame FSM.
   always_comb begin
      state_d    = state_q;
      hdr_cnt_d  = hdr_cnt_q;
      phase_d    = phase_q;
      col_d      = col_q;
      row_base_d = row_base_q;
      b_d        = b_q;
      g_d        = g_q;
      w_en_d     = 1'b0;
      addr_d     = addr_q;
      dat_d      = dat_q;
      done_d     = 1'b0;

      if (bus.abort) begin
         state_d    = S_IDLE;
         hdr_cnt_d  = '0;
         phase_d    = 2'd0;
         col_d      = '0;
         row_base_d = FIRST_BASE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  state_d    = (HDR_BYTES == 0) ? S_PIX : S_HDR;
                  hdr_cnt_d  = '0;
                  phase_d    = 2'd0;
                  col_d      = '0;
                  row_base_d = FIRST_BASE;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_HDR: begin
               if (bus.byte_vld && (hdr_cnt_q == HDR_END)) begin
                  state_d   = S_PIX;
                  hdr_cnt_d = '0;
               end else if (bus.byte_vld) begin
                  hdr_cnt_d = hdr_cnt_q + HDR_W'(1);
               end else begin
                  hdr_cnt_d = hdr_cnt_q;
               end
            end
            S_PIX: begin
               if (bus.byte_vld) begin
                  case (phase_q)
                     2'd0: begin
                        b_d     = bus.byte_dat[7:4];
                        phase_d = 2'd1;
                     end
                     2'd1: begin
                        g_d     = bus.byte_dat[7:4];
                        phase_d = 2'd2;
                     end
                     default: begin
                        phase_d = 2'd0;
                        w_en_d  = 1'b1;
                        addr_d  = row_base_q + 19'(col_q);
                        dat_d   = {bus.byte_dat[7:4], g_q, b_q};
                        // Row step happens on the column wrap, so no multiplier is needed.
                        if (col_q == COL_LAST) begin
                           col_d = '0;
                           if (row_base_q == LAST_BASE) begin
                              state_d = S_DONE;
                           end else if (BOTTOM_UP != 0) begin
                              row_base_d = row_base_q - ROW_STEP;
                           end else begin
                              row_base_d = row_base_q + ROW_STEP;
                           end
                        end else begin
                           col_d = col_q + COL_W'(1);
                        end
                     end
                  endcase
               end else begin
                  phase_d = phase_q;
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      busy_d = (state_d == S_HDR) || (state_d == S_PIX);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         hdr_cnt_q  <= '0;
         phase_q    <= 2'd0;
         col_q      <= '0;
         row_base_q <= 19'd0;
         b_q        <= 4'd0;
         g_q        <= 4'd0;
         w_en_q     <= 1'b0;
         addr_q     <= 19'd0;
         dat_q      <= 12'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         hdr_cnt_q  <= hdr_cnt_d;
         phase_q    <= phase_d;
         col_q      <= col_d;
         row_base_q <= row_base_d;
         b_q        <= b_d;
         g_q        <= g_d;
         w_en_q     <= w_en_d;
         addr_q     <= addr_d;
         dat_q      <= dat_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign bus.w_en   = w_en_q;
   assign bus.addr_w = addr_q;
   assign bus.dat_w  = dat_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
endmodule
